// File: rtl/mul_accumulator.sv
// mul_accumulator: registered accumulate stage behind the 16x16 signed array
// multiplier. Sums LENGTH consecutive 32-bit signed products into an
// ACC_BITS-wide signed accumulator. The sum is presented through a
// valid/ready handshake.
// Optional feature: define MUL_ACCUMULATOR_SATURATE_EN to clamp the
// accumulator on signed overflow. Without it, the accumulator wraps.
module mul_accumulator #(
    parameter int unsigned LENGTH   = 16,
    parameter int unsigned ACC_BITS = 40,
    parameter int unsigned CNT_BITS = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic signed [31:0]         product,
    input  logic                       inValid,
    output logic                       inReady,
    input  logic                       clear,
    output logic signed [ACC_BITS-1:0] result,
    output logic                       outValid,
    input  logic                       outReady,
    output logic                       overflow,
    output logic [CNT_BITS-1:0]        beatCount
);

    typedef enum logic [1:0] {
        ACCUM,
        DRAIN,
        DONE
    } state_t;

    localparam logic [CNT_BITS-1:0]        LAST_BEAT = CNT_BITS'(LENGTH);
    localparam logic signed [ACC_BITS-1:0] ACC_MAX   = {1'b0, {(ACC_BITS-1){1'b1}}};
    localparam logic signed [ACC_BITS-1:0] ACC_MIN   = {1'b1, {(ACC_BITS-1){1'b0}}};

    state_t                     state;
    state_t                     state_next;
    logic signed [31:0]         p_reg;
    logic                       p_valid;
    logic signed [ACC_BITS-1:0] acc;
    logic signed [ACC_BITS-1:0] addend;
    logic signed [ACC_BITS-1:0] sum;
    logic signed [ACC_BITS-1:0] add_value;
    logic                       add_ovf;
    logic                       ovf_flag;
    logic [CNT_BITS-1:0]        beat_cnt;
    logic [CNT_BITS-1:0]        beat_next;
    logic                       accept;
    logic                       take;
    logic                       last_beat;

    // Accept only while ready. An abort in the same cycle drops the product.
    assign accept    = inValid && inReady && !clear;
    assign take      = outValid && outReady;
    assign beat_next = beat_cnt + CNT_BITS'(1);
    assign last_beat = (beat_next == LAST_BEAT);

    assign result    = acc;
    assign overflow  = ovf_flag;
    assign beatCount = beat_cnt;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort overrides every state.
    // DRAIN waits until the captured final product has been added. The
    // completed sum is therefore stable when DONE starts.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (accept && last_beat) state_next = DRAIN;
                DRAIN:   if (!p_valid)            state_next = DONE;
                DONE:    if (outReady)            state_next = ACCUM;
                default:                          state_next = ACCUM;
            endcase
        end
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        inReady  = 1'b0;
        outValid = 1'b0;
        case (state)
            ACCUM:   inReady  = 1'b1;
            DRAIN:   inReady  = 1'b0;
            DONE:    outValid = 1'b1;
            default: inReady  = 1'b0;
        endcase
    end

    // Sign-extended add with overflow detection and optional clamping
    always_comb begin
        addend  = ACC_BITS'(p_reg);
        sum     = acc + addend;
        add_ovf = (acc[ACC_BITS-1] == addend[ACC_BITS-1]) &&
                  (sum[ACC_BITS-1] != acc[ACC_BITS-1]);
`ifdef MUL_ACCUMULATOR_SATURATE_EN
        if (add_ovf) begin
            add_value = acc[ACC_BITS-1] ? ACC_MIN : ACC_MAX;
        end else begin
            add_value = sum;
        end
`else
        add_value = sum;
`endif
    end

    // Capture stage, accumulate stage, beat counter and sticky overflow
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p_reg    <= '0;
            p_valid  <= 1'b0;
            acc      <= '0;
            beat_cnt <= '0;
            ovf_flag <= 1'b0;
        end else if (clear) begin
            p_valid  <= 1'b0;
            acc      <= '0;
            beat_cnt <= '0;
            ovf_flag <= 1'b0;
        end else begin
            p_valid <= accept;
            if (accept) begin
                p_reg    <= product;
                beat_cnt <= beat_next;
            end
            if (p_valid) begin
                acc <= add_value;
                if (add_ovf) begin
                    ovf_flag <= 1'b1;
                end
            end
            if (take) begin
                acc      <= '0;
                beat_cnt <= '0;
                ovf_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mul_accumulator.sv
// Testbench for mul_accumulator. It drives a default instance (LENGTH=16,
// ACC_BITS=40) and a narrow instance (LENGTH=2, ACC_BITS=32). Expected
// values come from a plain-integer model of the running sum.
module tb_mul_accumulator;

    localparam int unsigned LEN = 16;
    localparam int unsigned AB  = 40;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n;

    // default instance
    logic signed [31:0] product;
    logic               in_valid;
    logic               in_ready;
    logic               clear;
    logic signed [39:0] result;
    logic               out_valid;
    logic               out_ready;
    logic               overflow;
    logic [7:0]         beat_count;

    // narrow instance
    logic signed [31:0] n_product;
    logic               n_in_valid;
    logic               n_in_ready;
    logic               n_clear;
    logic signed [31:0] n_result;
    logic               n_out_valid;
    logic               n_out_ready;
    logic               n_overflow;
    logic [7:0]         n_beat_count;

    int checks   = 0;
    int failures = 0;

    logic signed [31:0] stim[$];

    mul_accumulator #(.LENGTH(16), .ACC_BITS(40), .CNT_BITS(8)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .product  (product),
        .inValid  (in_valid),
        .inReady  (in_ready),
        .clear    (clear),
        .result   (result),
        .outValid (out_valid),
        .outReady (out_ready),
        .overflow (overflow),
        .beatCount(beat_count)
    );

    mul_accumulator #(.LENGTH(2), .ACC_BITS(32), .CNT_BITS(8)) dut_narrow (
        .clock    (clock),
        .reset_n  (reset_n),
        .product  (n_product),
        .inValid  (n_in_valid),
        .inReady  (n_in_ready),
        .clear    (n_clear),
        .result   (n_result),
        .outValid (n_out_valid),
        .outReady (n_out_ready),
        .overflow (n_overflow),
        .beatCount(n_beat_count)
    );

    // Reference: signed running sum over stim with wrap or clamp at acc_bits
    task automatic model_run(input int acc_bits, output longint res, output bit ovf);
        longint one  = 1;
        longint maxv = (one << (acc_bits - 1)) - 1;
        longint minv = -maxv - 1;
        longint span = one << acc_bits;
        longint s    = 0;
        longint t;
        ovf = 1'b0;
        foreach (stim[i]) begin
            t = s + longint'(stim[i]);
            if (t > maxv) begin
                ovf = 1'b1;
`ifdef MUL_ACCUMULATOR_SATURATE_EN
                s = maxv;
`else
                s = t - span;
`endif
            end else if (t < minv) begin
                ovf = 1'b1;
`ifdef MUL_ACCUMULATOR_SATURATE_EN
                s = minv;
`else
                s = t + span;
`endif
            end else begin
                s = t;
            end
        end
        res = s;
    endtask

    // Feed stim into the default instance, then check latency, DONE hold and handshake
    task automatic run_stream(input int gap_max, input int hold_cycles, input string name);
        longint     exp_res;
        bit         exp_ovf;
        logic [39:0] exp;
        int         lat;
        model_run(AB, exp_res, exp_ovf);
        exp = exp_res[39:0];
        foreach (stim[i]) begin
            repeat ($urandom_range(gap_max, 0)) begin
                in_valid = 1'b0;
                product  = $urandom;
                @(negedge clock);
            end
            in_valid = 1'b1;
            product  = stim[i];
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL %s in_ready beat %0d: got %b want 1", name, i, in_ready);
            end
            @(negedge clock);
            checks++;
            if (beat_count !== 8'(i + 1)) begin
                failures++;
                $display("FAIL %s beat_count beat %0d: got %0d want %0d", name, i, beat_count, i + 1);
            end
        end
        // keep offering data during DRAIN/DONE; it must not be taken
        in_valid = 1'b1;
        product  = $urandom;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s drain_in_ready: got %b want 0", name, in_ready);
            end
            @(negedge clock);
            lat++;
        end
        checks++;
        if (lat != 2) begin
            failures++;
            $display("FAIL %s latency: got %0d cycles want 2", name, lat);
        end
        out_ready = 1'b0;
        for (int k = 0; k < hold_cycles; k++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || beat_count !== 8'(LEN)) begin
                failures++;
                $display("FAIL %s hold_ctrl cycle %0d: got valid=%b ready=%b beats=%0d want 1 0 %0d",
                         name, k, out_valid, in_ready, beat_count, LEN);
            end
            checks++;
            if (result !== exp || overflow !== exp_ovf) begin
                failures++;
                $display("FAIL %s hold_result cycle %0d: got %h/%b want %h/%b",
                         name, k, result, overflow, exp, exp_ovf);
            end
            product = $urandom;
            @(negedge clock);
        end
        checks++;
        if (out_valid !== 1'b1 || result !== exp || overflow !== exp_ovf) begin
            failures++;
            $display("FAIL %s result: got valid=%b %h ovf=%b want 1 %h ovf=%b",
                     name, out_valid, result, overflow, exp, exp_ovf);
        end
        out_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || beat_count !== 8'd0 ||
            result !== 40'd0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL %s after_take: got valid=%b ready=%b beats=%0d res=%h ovf=%b want 0 1 0 0 0",
                     name, out_valid, in_ready, beat_count, result, overflow);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        product     = '0;
        in_valid    = 1'b0;
        clear       = 1'b0;
        out_ready   = 1'b1;
        n_product   = '0;
        n_in_valid  = 1'b0;
        n_clear     = 1'b0;
        n_out_ready = 1'b1;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 40'd0 ||
            overflow !== 1'b0 || beat_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_state: got ready=%b valid=%b res=%h ovf=%b beats=%0d want 1 0 0 0 0",
                     in_ready, out_valid, result, overflow, beat_count);
        end
        checks++;
        if (n_in_ready !== 1'b1 || n_out_valid !== 1'b0 || n_result !== 32'd0) begin
            failures++;
            $display("FAIL reset_narrow: got ready=%b valid=%b res=%h want 1 0 0",
                     n_in_ready, n_out_valid, n_result);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_patterns();
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back(32'sh00000001);
        run_stream(0, 0, "ones");
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back(32'shFFFFFFFF);
        run_stream(0, 0, "minus_ones");
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back((i % 2 == 0) ? 32'sh40000000 : 32'shC0000000);
        run_stream(0, 0, "alternating");
    endtask

    task automatic test_backpressure();
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back($urandom);
        run_stream(0, 5, "backpressure");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            stim.delete();
            for (int i = 0; i < 16; i++) stim.push_back($urandom);
            run_stream(2, int'($urandom_range(3, 0)), "random");
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            product  = 32'sd5;
            @(negedge clock);
        end
        clear    = 1'b1;
        in_valid = 1'b1;
        product  = 32'sd5;
        @(negedge clock);
        clear    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (beat_count !== 8'd0 || result !== 40'd0 || overflow !== 1'b0 ||
            out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL clear_state: got beats=%0d res=%h ovf=%b valid=%b ready=%b want 0 0 0 0 1",
                     beat_count, result, overflow, out_valid, in_ready);
        end
        @(negedge clock);
        checks++;
        if (result !== 40'd0 || beat_count !== 8'd0) begin
            failures++;
            $display("FAIL clear_dropped: got res=%h beats=%0d want 0 0", result, beat_count);
        end
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back(32'sd2);
        run_stream(0, 0, "after_clear");
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            product  = 32'sd3;
            @(negedge clock);
        end
        checks++;
        if (beat_count !== 8'd10) begin
            failures++;
            $display("FAIL pre_reset_beats: got %0d want 10", beat_count);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (beat_count !== 8'd0 || result !== 40'd0 || out_valid !== 1'b0 ||
            overflow !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: got beats=%0d res=%h valid=%b ovf=%b ready=%b want 0 0 0 0 1",
                     beat_count, result, out_valid, overflow, in_ready);
        end
        in_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back(32'sd3);
        run_stream(0, 0, "after_reset");
    endtask

    // One LENGTH=2 result on the narrow instance
    task automatic narrow_pair(input logic signed [31:0] a, input logic signed [31:0] b,
                               input string name);
        longint exp_res;
        bit     exp_ovf;
        int     wait_cnt;
        stim.delete();
        stim.push_back(a);
        stim.push_back(b);
        model_run(32, exp_res, exp_ovf);
        n_in_valid = 1'b1;
        n_product  = a;
        @(negedge clock);
        n_product  = b;
        @(negedge clock);
        n_in_valid = 1'b0;
        wait_cnt = 0;
        while (n_out_valid !== 1'b1 && wait_cnt < 10) begin
            @(negedge clock);
            wait_cnt++;
        end
        checks++;
        if (n_out_valid !== 1'b1 || n_result !== exp_res[31:0] || n_overflow !== exp_ovf) begin
            failures++;
            $display("FAIL %s: got valid=%b res=%h ovf=%b want 1 %h %b",
                     name, n_out_valid, n_result, n_overflow, exp_res[31:0], exp_ovf);
        end
        @(negedge clock);
        checks++;
        if (n_out_valid !== 1'b0 || n_overflow !== 1'b0 || n_beat_count !== 8'd0) begin
            failures++;
            $display("FAIL %s take: got valid=%b ovf=%b beats=%0d want 0 0 0",
                     name, n_out_valid, n_overflow, n_beat_count);
        end
    endtask

    task automatic test_narrow();
        narrow_pair(32'sh7FFFFFFF, 32'sh7FFFFFFF, "narrow_max");
        narrow_pair(32'sh80000000, 32'sh80000000, "narrow_min");
        for (int r = 0; r < 6; r++) begin
            narrow_pair($urandom, $urandom, "narrow_random");
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_backpressure();
        test_random();
        test_clear();
        test_async_reset();
        test_narrow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_accumulator.md
Name: mul_accumulator

Overview:
- Sequential stage directly downstream of the 16x16 signed array multiplier (c2_array_multiplier); consumes its 32-bit two's-complement product.
- Sums LENGTH consecutive products into a wide signed accumulator.
- Presents the sum through a valid/ready handshake for dot-product and MAC operations in the ALU32 datapath.
- Multiplier stays combinational; this block adds the only register stages on the multiply path.

Parameters:
- LENGTH, 16: number of products summed per result; legal range 1..255.
- ACC_BITS, 40: accumulator and result width, signed; legal range 32..64.
- CNT_BITS, 8: beat counter width; must satisfy 2^CNT_BITS > LENGTH.

Ports:
- clock  in  1  single clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- product  in  32  signed product from the multiplier; sampled only when inValid && inReady.
- inValid  in  1  product is valid this cycle.
- inReady  out  1  block accepts a product this cycle.
- clear  in  1  synchronous abort; discards partial sum.
- result  out  ACC_BITS  signed accumulated sum; stable while outValid=1.
- outValid  out  1  result available.
- outReady  in  1  consumer takes result.
- overflow  out  1  sticky flag: signed overflow occurred in the current result.
- beatCount  out  CNT_BITS  products accepted so far in the current result.

Behaviour:
- Reset (async assert, sync release) forces the following:
  - state=ACCUM, acc=0, pReg=0, pValid=0, beatCount=0.
  - result=0, outValid=0, overflow=0, inReady=1.
- Stage 1 (capture): on accept, product goes to pReg and pValid=1 next cycle; otherwise pValid=0. beatCount increments on each accept.
- Stage 2 (add): when pValid=1, acc <= acc + sign_extend(pReg, ACC_BITS). Wraps modulo 2^ACC_BITS unless SATURATE_EN is defined.
- overflow is set when the operand signs are equal and the sum's sign differs. It stays set until the result is taken, a clear occurs, or reset.
- State ACCUM:
  - inReady=1.
  - The accept that makes beatCount reach LENGTH moves the state to DRAIN.
- State DRAIN:
  - inReady=0.
  - Final add completes; next state is DONE.
- State DONE:
  - inReady=0, outValid=1, result=acc.
  - result and overflow hold steady while outReady=0.
  - On outValid && outReady: acc, beatCount and overflow are cleared, outValid drops, state returns to ACCUM. inReady=1 in the following cycle; there is no same-cycle turnaround.
- Latency: outValid rises 2 cycles after the clock edge that accepts the LENGTH-th product.
- Throughput: one product per cycle; LENGTH+3 cycles per result minimum.
- clear has highest priority in every state:
  - next cycle: acc=0, pValid=0, beatCount=0, overflow=0, outValid=0, state=ACCUM.
  - A product offered in the same cycle as clear is dropped, not accepted.
- LENGTH=1: the first accept goes straight to DRAIN.
- inValid while inReady=0: no effect, no capture. The upstream holds its data.
- Reset mid-operation: all state discarded immediately; no partial result is emitted.

Optional Feature:
- Macro: MUL_ACCUMULATOR_SATURATE_EN.
- Defined: on signed overflow, acc clamps to the max positive value (0111..1) or the min negative value (1000..0) per the operand sign. overflow is still set. Later adds continue from the clamped value.
- Undefined: two's-complement wrap; overflow flags the event only.

Test Plan:
- Defaults, 16 beats product=32'h00000001 back-to-back, outReady=1 -> outValid high 2 cycles after the 16th accept; result=40'h0000000010, overflow=0, inReady low during DRAIN/DONE.
- Defaults, 16 beats product=32'hFFFFFFFF (-1) -> result=40'hFFFFFFFFF0 (-16); then 16 beats alternating 32'h40000000 and 32'hC0000000 -> result=0.
- Backpressure: outReady=0 for 5 cycles in DONE with inValid=1 held -> result stable, inReady=0, no beat accepted; outReady=1 -> handshake completes, ACCUM resumes with beatCount=0.
- clear asserted after 7 beats of 32'h00000005, with inValid=1 in the same cycle -> next cycle beatCount=0, acc=0; a following full run of 16 x 32'h00000002 gives result=32.
- ACC_BITS=32, LENGTH=2, products 32'h7FFFFFFF twice -> without macro result=32'hFFFFFFFE, overflow=1; with MUL_ACCUMULATOR_SATURATE_EN result=32'h7FFFFFFF, overflow=1.
- reset_n pulsed low asynchronously (between clock edges) after 10 beats -> outputs go to reset values at once, before the next clock edge; a subsequent 16-beat run of 32'h00000003 gives result=48.
